prog_tick_timer: RTL and testbench
==================================

Name: prog_tick_timer

Overview:
- Parametrised successor of the fixed 1 s tick generator.
- Counts strobes on tick_in and emits a one-cycle tick_out every PERIOD strobes.
- Period is loadable at run time. Supports periodic and one-shot modes, plus start, pause and clear control.
- Used for game-phase timers (second ticks, countdowns, power-up durations). Chainable: tick_out of one instance feeds tick_in of the next.

Parameters:
- CW, 16: counter/period width in bits.
- DEFAULT_PERIOD, 1000: period after reset, in tick_in strobes; must satisfy 1 <= DEFAULT_PERIOD < 2**CW.
- AUTO_START, 1: 1 = RUN after reset; 0 = IDLE after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_in  in  1  input strobe, one clk wide (e.g. 1 ms tick)
- start  in  1  pulse; IDLE/PAUSE/DONE -> RUN
- stop  in  1  pulse; RUN -> PAUSE, count held
- clear  in  1  pulse; count := 0, state := IDLE
- oneshot  in  1  mode: 0 periodic, 1 one-shot
- period_load  in  1  pulse; latch period_in
- period_in  in  CW  new period in strobes
- tick_out  out  1  one-cycle pulse at each period expiry
- running  out  1  high in RUN
- done  out  1  high in DONE (one-shot expired)
- count  out  CW  current strobe count, 0..period-1

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all flops update on posedge clk only.
- Reset values:
  - tick_out=0, count=0, done=0.
  - period=DEFAULT_PERIOD, pending_period invalid.
  - state=RUN if AUTO_START else IDLE; running follows state.
- States: IDLE, RUN, PAUSE, DONE; 2-bit encoding from the package. Outputs are decoded from registered state.
- Transitions, priority clear > stop > start:
  - clear: any state -> IDLE; count=0; pending period load is applied immediately.
  - stop: RUN -> PAUSE; ignored elsewhere.
  - start: IDLE/PAUSE -> RUN, count preserved; DONE -> RUN with count=0.
  - start and stop in the same cycle: stop wins.
- Counting happens only in RUN, and only in cycles with tick_in=1 and no clear/stop that cycle. A tick_in in the same cycle as start is not counted.
- Expiry is when count == period-1 and a qualifying tick_in arrives:
  - count wraps to 0.
  - tick_out=1 in the next cycle only (registered, latency 1 clk from the tick_in edge).
  - If oneshot=1, state -> DONE in that same cycle. oneshot is sampled on the expiry cycle.
- No tick is generated without a tick_in. Any count >= period-1 with tick_in also counts as expiry; this is the defensive path.
- Period load:
  - period_in=0 is ignored.
  - In IDLE, PAUSE or DONE the new period applies next cycle.
  - In RUN it is held pending and applied on the next expiry, or on clear, so the running period is never cut short.
  - A second load before the pending one is applied overwrites it.
- Period 1: tick_out follows every tick_in by 1 clk.
- Maximum period is 2**CW-1. The count arithmetic is CW bits and never overflows because it wraps at period-1.
- A reset mid-operation discards the pending period and count.

Decomposition:
- Package timer_pkg holds:
  - state typedef and encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3;
  - default constants: MS_PER_SEC=1000, default CW=16.
- One natural sub-module: prog_tick_timer_period_reg. It holds the active and pending period and the apply-on-expiry logic, and keeps the main FSM/counter file clean.

Test Plan:
- Run with DEFAULT_PERIOD=1000, tick_in every 10 clk, periodic -> tick_out pulses exactly 1 clk wide, 10000 clk apart. First pulse comes 1 clk after the 1000th strobe; count returns to 0.
- Set oneshot=1, period_load=1 with period_in=5, then start; apply 7 strobes -> exactly one tick_out after strobe 5, done=1, running=0, count stays 0. Then start -> RUN, count=0.
- Stop at count=3 and send 4 strobes -> count stays 3, no tick_out. Start and send 2 strobes -> count=5. Start and stop asserted together in PAUSE -> state stays PAUSE.
- In RUN with period 10 at count=4, load period 3 -> expiry still after strobe 10. The next period is 3 strobes. period_in=0 -> period unchanged.
- Apply clear while count=7 together with tick_in=1 -> count=0, IDLE, no tick_out. Apply rst mid-count -> all outputs at reset values next cycle.
- Period 1 with back-to-back tick_in on consecutive clks -> tick_out high continuously, 1 clk delayed.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable tick timer family.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

    localparam int MS_PER_SEC = 1000;
    localparam int DEFAULT_CW = 16;

endpackage

// File: rtl/prog_tick_timer_period_reg.sv
// Active and pending period storage; a load while running waits for the next expiry or clear.
module prog_tick_timer_period_reg
    import timer_pkg::*;
#(
    parameter int CW             = DEFAULT_CW,
    parameter int DEFAULT_PERIOD = MS_PER_SEC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_run,
    input  logic          expire,
    input  logic          clear,
    input  logic          period_load,
    input  logic [CW-1:0] period_in,
    output logic [CW-1:0] period
);

    logic [CW-1:0] pend_period;
    logic          pend_vld;
    logic          load_ok;

    assign load_ok = period_load && (period_in != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            period   <= CW'(DEFAULT_PERIOD);
            pend_vld <= 1'b0;
        end else if (load_ok && (!in_run || clear)) begin
            period   <= period_in;
            pend_vld <= 1'b0;
        end else begin
            // Apply the held value first; a load in the same cycle becomes the next pending one.
            if ((expire || clear) && pend_vld) begin
                period   <= pend_period;
                pend_vld <= 1'b0;
            end
            if (load_ok) begin
                pend_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            pend_period <= period_in;
        end
    end

endmodule

// File: rtl/prog_tick_timer.sv
// Programmable strobe-counting timer: periodic or one-shot tick_out every PERIOD tick_in strobes.
module prog_tick_timer
    import timer_pkg::*;
#(
    parameter int CW             = DEFAULT_CW,
    parameter int DEFAULT_PERIOD = MS_PER_SEC,
    parameter bit AUTO_START     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    input  logic          oneshot,
    input  logic          period_load,
    input  logic [CW-1:0] period_in,
    output logic          tick_out,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] count
);

    timer_state_e  state;
    logic [CW-1:0] period;
    logic          qual_tick;
    logic          expire;

    assign qual_tick = (state == RUN) && tick_in && !clear && !stop && !start;
    // >= rather than == keeps the counter bounded if period shrinks below count.
    assign expire    = qual_tick && (count >= period - 1'b1);

    prog_tick_timer_period_reg #(
        .CW             (CW),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_period_reg (
        .clk         (clk),
        .rst         (rst),
        .in_run      (state == RUN),
        .expire      (expire),
        .clear       (clear),
        .period_load (period_load),
        .period_in   (period_in),
        .period      (period)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= AUTO_START ? RUN : IDLE;
            count    <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= expire;
            if (clear) begin
                state <= IDLE;
                count <= '0;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= PAUSE;
                end
            end else if (start) begin
                if (state != RUN) begin
                    state <= RUN;
                    if (state == DONE) begin
                        count <= '0;
                    end
                end
            end else if (expire) begin
                count <= '0;
                if (oneshot) begin
                    state <= DONE;
                end
            end else if (qual_tick) begin
                count <= count + 1'b1;
            end
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed bench for prog_tick_timer with a tick_out scoreboard.
module tb_prog_tick_timer;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          oneshot = 1'b0;
    logic          period_load = 1'b0;
    logic [CW-1:0] period_in = '0;
    logic          tick_out;
    logic          running;
    logic          done;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q[$];

    prog_tick_timer #(
        .CW             (CW),
        .DEFAULT_PERIOD (1000),
        .AUTO_START     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .oneshot     (oneshot),
        .period_load (period_load),
        .period_in   (period_in),
        .tick_out    (tick_out),
        .running     (running),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every tick_out pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (tick_out) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tick_out_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL tick_out_cycle: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic strobe(input bit exp_tick, input int gap);
        tick_in = 1'b1;
        if (exp_tick) exp_q.push_back(cyc + 1);
        step();
        tick_in = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic load(input int p);
        period_load = 1'b1;
        period_in   = CW'(p);
        step();
        period_load = 1'b0;
        period_in   = '0;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("reset_count", count, 0);
        chk("reset_running", running, 1);
        chk("reset_done", done, 0);
        chk("reset_tick_out", tick_out, 0);

        // Default period 1000, strobes every 10 clk, periodic
        for (int i = 0; i < 2000; i++) strobe((i % 1000) == 999, 9);
        chk("default_count_wrap", count, 0);
        chk("default_all_ticks_seen", exp_q.size(), 0);

        // One-shot period 5
        pulse_clear();
        oneshot = 1'b1;
        load(5);
        pulse_start();
        for (int i = 1; i <= 7; i++) strobe(i == 5, 1);
        chk("oneshot_done", done, 1);
        chk("oneshot_running", running, 0);
        chk("oneshot_count", count, 0);
        pulse_start();
        chk("oneshot_restart_running", running, 1);
        chk("oneshot_restart_done", done, 0);
        chk("oneshot_restart_count", count, 0);
        oneshot = 1'b0;

        // Pause holds count
        pulse_clear();
        load(10);
        pulse_start();
        for (int i = 0; i < 3; i++) strobe(1'b0, 1);
        chk("pause_pre_count", count, 3);
        pulse_stop();
        for (int i = 0; i < 4; i++) strobe(1'b0, 1);
        chk("pause_held_count", count, 3);
        chk("pause_running", running, 0);
        pulse_start();
        for (int i = 0; i < 2; i++) strobe(1'b0, 1);
        chk("resume_count", count, 5);
        pulse_stop();
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("start_stop_pause_running", running, 0);
        chk("start_stop_pause_count", count, 5);

        // Pending period load while running
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 4; i++) strobe(1'b0, 1);
        chk("pending_pre_count", count, 4);
        load(3);
        for (int i = 5; i <= 10; i++) strobe(i == 10, 1);
        chk("pending_expiry_count", count, 0);
        for (int i = 1; i <= 3; i++) strobe(i == 3, 1);
        load(0);
        for (int i = 1; i <= 3; i++) strobe(i == 3, 1);
        chk("zero_load_ignored_count", count, 0);

        // Clear together with tick_in, then reset mid-count
        load(10);
        for (int i = 1; i <= 3; i++) strobe(i == 3, 1);
        for (int i = 0; i < 7; i++) strobe(1'b0, 1);
        chk("clear_pre_count", count, 7);
        clear = 1'b1; tick_in = 1'b1; step(); clear = 1'b0; tick_in = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_running", running, 0);
        chk("clear_done", done, 0);
        step();
        chk("clear_no_tick", tick_out, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) strobe(1'b0, 1);
        chk("pre_rst_count", count, 4);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_running", running, 1);
        chk("midrst_done", done, 0);
        chk("midrst_tick_out", tick_out, 0);
        for (int i = 0; i < 999; i++) strobe(1'b0, 0);
        chk("midrst_default_period_count", count, 999);

        // Period 1 with back-to-back strobes
        pulse_clear();
        load(1);
        pulse_start();
        for (int i = 0; i < 8; i++) strobe(1'b1, 0);
        repeat (3) step();
        chk("period1_count", count, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
